ce_gen_multi: RTL and testbench

- Parametrised multi-channel clock-enable generator, built as a per-channel phase-accumulator NCO.
- Derives NUM_CH fractional-rate, phase-alignable single-cycle enables (e.g. 14.318/7.159/12.27 MHz-equivalent rates) from one fast system clock.
- Replaces per-rate fabric PLL outputs; all downstream logic stays in one clock domain.
- Sits directly after the system PLL output; feeds video, CPU and audio clock enables.

---
 rtl/ce_gen_multi.sv | 138 +++++++++++++
 tb/tb_ce_gen_multi.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ce_gen_multi.sv
// Multi-channel phase-accumulator clock-enable generator with glitch-free rate change and lock detect.
// Optional CE_GEN_SQUARE_EN adds per-channel ~50% duty square outputs (sq).
module ce_gen_multi #(
    parameter  int unsigned NUM_CH      = 5,
    parameter  int unsigned ACC_W       = 32,
    parameter  int unsigned LOCK_CYCLES = 1024,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    input  logic              sync,
    output logic [NUM_CH-1:0] ce,
    output logic              locked
`ifdef CE_GEN_SQUARE_EN
    ,
    output logic [NUM_CH-1:0] sq
`endif
);

    localparam int unsigned LK_W = $clog2(LOCK_CYCLES + 1);

    logic              r_ready;
    logic [ACC_W-1:0]  r_acc    [NUM_CH];
    logic [ACC_W-1:0]  r_inc    [NUM_CH];
    logic [ACC_W-1:0]  r_inc_sh [NUM_CH];
    logic [ACC_W-1:0]  r_phase  [NUM_CH];
    logic [NUM_CH-1:0] r_ce;
    logic [LK_W-1:0]   r_lock_cnt;
    logic              r_locked;

    logic              w_wr;
    logic              w_wr_hit;
    logic [NUM_CH-1:0] w_sel;
    logic [ACC_W:0]    w_sum    [NUM_CH];

    assign cfg_ready = r_ready & ~sync;
    assign w_wr      = cfg_valid & cfg_ready;
    assign w_wr_hit  = |w_sel;
    assign ce        = r_ce;
    assign locked    = r_locked;

    // Channel decode; out-of-range channels select nothing and are dropped.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_sel[i] = w_wr && (cfg_ch == CH_W'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_sum[i] = {1'b0, r_acc[i]} + {1'b0, r_inc[i]};
        end
    end

    // Released-reset flag: config becomes acceptable one edge after rst_n rises.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
        end
    end

    // Accumulators; active increment only follows the shadow at a carry, when idle, or on sync.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_ce <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i]    <= '0;
                r_inc[i]    <= '0;
                r_inc_sh[i] <= '0;
                r_phase[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_sel[i]) begin
                    r_phase[i]  <= cfg_phase;
                    r_inc_sh[i] <= cfg_inc;
                end
                if (sync) begin
                    r_acc[i] <= r_phase[i];
                    r_inc[i] <= r_inc_sh[i];
                    r_ce[i]  <= 1'b0;
                end else begin
                    r_acc[i] <= w_sum[i][ACC_W-1:0];
                    r_ce[i]  <= w_sum[i][ACC_W];
                    if (w_sum[i][ACC_W] || (r_inc[i] == '0)) begin
                        r_inc[i] <= r_inc_sh[i];
                    end
                end
            end
        end
    end

    // Settle counter: restarts on any effective reconfiguration or realignment.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (sync || w_wr_hit) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (r_lock_cnt != LK_W'(LOCK_CYCLES)) begin
            r_lock_cnt <= r_lock_cnt + LK_W'(1);
            r_locked   <= (r_lock_cnt == LK_W'(LOCK_CYCLES - 1));
        end
    end

`ifdef CE_GEN_SQUARE_EN
    logic [NUM_CH-1:0] r_sq;

    assign sq = r_sq;

    // Square output tracks the accumulator MSB; held low for idle channels.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sq <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_inc[i] == '0) begin
                    r_sq[i] <= 1'b0;
                end else if (sync) begin
                    r_sq[i] <= r_phase[i][ACC_W-1];
                end else begin
                    r_sq[i] <= w_sum[i][ACC_W-1];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ce_gen_multi.sv
// Directed self-checking bench for ce_gen_multi (NUM_CH=5, ACC_W=32, LOCK_CYCLES=16).
module tb_ce_gen_multi;

    logic        refclk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_ch;
    logic [31:0] cfg_inc;
    logic [31:0] cfg_phase;
    logic        sync;
    logic [4:0]  ce;
    logic        locked;

    int n_checks = 0;
    int n_fail   = 0;

    ce_gen_multi #(
        .NUM_CH     (5),
        .ACC_W      (32),
        .LOCK_CYCLES(16)
    ) dut (
        .refclk   (refclk),
        .rst_n    (rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_inc  (cfg_inc),
        .cfg_phase(cfg_phase),
        .sync     (sync),
        .ce       (ce),
        .locked   (locked)
    );

    always #5 refclk = ~refclk;

    task automatic tick;
        @(posedge refclk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [31:0] inc, input logic [31:0] ph);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_inc   = inc;
        cfg_phase = ph;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_sync;
        sync = 1'b1;
        tick();
        sync = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (ce !== 5'b0 || locked !== 1'b0 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state ce=%b locked=%b ready=%b required 00000/0/0", ce, locked, cfg_ready);
        end
        rst_n = 1'b1;
        n_checks++;
        if (cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready ready=%b required 0", cfg_ready);
        end
        tick();
        n_checks++;
        if (cfg_ready !== 1'b1 || ce !== 5'b0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL first_edge ready=%b ce=%b locked=%b required 1/00000/0", cfg_ready, ce, locked);
        end
    endtask

    task automatic test_half_rate;
        logic [4:0] exp;
        cfg_write(3'd0, 32'h8000_0000, 32'h0);
        do_sync();
        n_checks++;
        if (ce !== 5'b0) begin
            n_fail++;
            $display("FAIL half_rate_sync ce=%b required 00000", ce);
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp = (k % 2 == 0) ? 5'b00001 : 5'b00000;
            n_checks++;
            if (ce !== exp) begin
                n_fail++;
                $display("FAIL half_rate k=%0d ce=%b required %b", k, ce, exp);
            end
        end
    endtask

    task automatic test_phase_align;
        logic [4:0] exp;
        cfg_write(3'd1, 32'h4000_0000, 32'h8000_0000);
        cfg_write(3'd0, 32'h4000_0000, 32'h0);
        do_sync();
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp = 5'b0;
            exp[1] = (k % 4 == 2);
            exp[0] = (k % 4 == 0);
            n_checks++;
            if (ce !== exp) begin
                n_fail++;
                $display("FAIL phase_align k=%0d ce=%b required %b", k, ce, exp);
            end
        end
    endtask

    task automatic test_rate_change;
        logic exp;
        cfg_write(3'd2, 32'h4000_0000, 32'h0);
        do_sync();
        for (int k = 1; k <= 26; k++) begin
            if (k == 6) begin
                cfg_valid = 1'b1;
                cfg_ch    = 3'd2;
                cfg_inc   = 32'h2000_0000;
                cfg_phase = 32'h0;
            end
            tick();
            cfg_valid = 1'b0;
            exp = (k == 4) || (k == 8) || (k == 16) || (k == 24);
            n_checks++;
            if (ce[2] !== exp) begin
                n_fail++;
                $display("FAIL rate_change k=%0d ce2=%b required %b", k, ce[2], exp);
            end
        end
    endtask

    task automatic test_lock;
        logic exp;
        cfg_write(3'd3, 32'h0, 32'h0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp = (k == 16);
            n_checks++;
            if (locked !== exp) begin
                n_fail++;
                $display("FAIL lock_first k=%0d locked=%b required %b", k, locked, exp);
            end
        end
        cfg_write(3'd7, 32'h1234_5678, 32'h0);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_bad_ch locked=%b required 1", locked);
        end
        cfg_write(3'd3, 32'h0, 32'h0);
        for (int k = 1; k <= 15; k++) tick();
        cfg_write(3'd3, 32'h0, 32'h0);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_rewrite locked=%b required 0", locked);
        end
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp = (k == 16);
            n_checks++;
            if (locked !== exp) begin
                n_fail++;
                $display("FAIL lock_second k=%0d locked=%b required %b", k, locked, exp);
            end
        end
    endtask

    task automatic test_sync_vs_cfg;
        logic exp;
        sync      = 1'b1;
        cfg_valid = 1'b1;
        cfg_ch    = 3'd4;
        cfg_inc   = 32'h8000_0000;
        cfg_phase = 32'h0;
        #1;
        n_checks++;
        if (cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_ready ready=%b required 0", cfg_ready);
        end
        tick();
        sync = 1'b0;
        #1;
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sync_drop_ready ready=%b required 1", cfg_ready);
        end
        tick();
        cfg_valid = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            tick();
            exp = (k == 4) || (k == 6);
            n_checks++;
            if (ce[4] !== exp) begin
                n_fail++;
                $display("FAIL sync_vs_cfg edge=%0d ce4=%b required %b", k, ce[4], exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit found = 0;
        for (int k = 0; k < 20; k++) tick();
        for (int k = 0; k < 10 && !found; k++) begin
            if (ce[4] === 1'b1) found = 1;
            else tick();
        end
        n_checks++;
        if (!found || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_activity found=%0d locked=%b required 1/1", found, locked);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ce !== 5'b0 || locked !== 1'b0 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset ce=%b locked=%b ready=%b required 00000/0/0", ce, locked, cfg_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_ready ready=%b required 1", cfg_ready);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++;
            if (ce !== 5'b0 || locked !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle k=%0d ce=%b locked=%b required 00000/0", k, ce, locked);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 3'd0;
        cfg_inc   = 32'h0;
        cfg_phase = 32'h0;
        sync      = 1'b0;
        test_reset();
        test_half_rate();
        test_phase_align();
        test_rate_change();
        test_lock();
        test_sync_vs_cfg();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
